pilha_param: RTL and testbench

PILHA_PARAM -- requirements
Module: pilha_param

---
 rtl/pilha_param_if.sv | 47 ++++
 rtl/pilha_param.sv | 135 +++++++++++++
 tb/tb_pilha_param.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pilha_param_if.sv
// pilha_param_if -- signal bundle for the parameterised LIFO stack.
// Request side (push/pop/din/clr_err) and status side (dout/count/empty/
// full/ovf/udf) travel together. clk and rst stay plain module ports.
// The master drives requests and the slave (the stack) drives status.
interface pilha_param_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] din;
    logic              clr_err;
    logic [DATA_W-1:0] dout;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              ovf;
    logic              udf;

    modport master (
        output push,
        output pop,
        output din,
        output clr_err,
        input  dout,
        input  count,
        input  empty,
        input  full,
        input  ovf,
        input  udf
    );

    modport slave (
        input  push,
        input  pop,
        input  din,
        input  clr_err,
        output dout,
        output count,
        output empty,
        output full,
        output ovf,
        output udf
    );
endinterface

// File: rtl/pilha_param.sv
// pilha_param -- parameterised LIFO stack (register array + count).
// Entry count-1 is the top of stack; dout is a combinational read of it.
// Optional build macro: PILHA_ERR_STICKY_EN makes ovf/udf sticky until a
// cycle with clr_err=1 (an error in that same cycle keeps the flag set).
// Without the macro ovf/udf are one-cycle registered pulses and clr_err
// is ignored.
//
// Request semantics (sampled on every rising clk edge, no backpressure):
//   push only  : store din on top if not full, otherwise overflow
//   pop only   : drop the top if not empty, otherwise underflow
//   push & pop : replace the top with din (plain push when empty)
//   neither    : hold
// Status outputs come from registers only, so they change one cycle after
// the edge that caused the change.
module pilha_param #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input logic           clk,
    input logic           rst,
    pilha_param_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage is intentionally not reset; it is never observable when empty.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic              udf_q;

    logic              empty_w;
    logic              full_w;
    logic              inc;
    logic              dec;
    logic              repl;
    logic              wr_en;
    logic              ovf_ev;
    logic              udf_ev;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  cnt_idx;
    logic [IDX_W-1:0]  wr_idx;

    assign empty_w = (cnt_q == '0);
    assign full_w  = (cnt_q == CNT_W'(DEPTH));

    // Index of the current top and of the next free slot. cnt_idx is only
    // used for a write when the stack is not full, so truncation is safe.
    assign top_idx = IDX_W'(cnt_q - CNT_W'(1));
    assign cnt_idx = IDX_W'(cnt_q);

    // Decode one request cycle into a single action.
    always_comb begin
        inc    = 1'b0;
        dec    = 1'b0;
        repl   = 1'b0;
        ovf_ev = 1'b0;
        udf_ev = 1'b0;
        if (bus.push && !bus.pop) begin
            if (full_w) ovf_ev = 1'b1;
            else        inc    = 1'b1;
        end else if (bus.pop && !bus.push) begin
            if (empty_w) udf_ev = 1'b1;
            else         dec    = 1'b1;
        end else if (bus.push && bus.pop) begin
            // On an empty stack a simultaneous push/pop is a plain push.
            if (empty_w) inc  = 1'b1;
            else         repl = 1'b1;
        end
    end

    assign wr_en  = inc | repl;
    assign wr_idx = repl ? top_idx : cnt_idx;

    // Storage write: new top on push, in-place overwrite on push&pop.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= bus.din;
        end
    end

    // Occupancy counter; inc/dec are already guarded against full/empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (dec) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

`ifdef PILHA_ERR_STICKY_EN
    // Sticky error flags: set wins over clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_ev | (ovf_q & ~bus.clr_err);
            udf_q <= udf_ev | (udf_q & ~bus.clr_err);
        end
    end
`else
    // Error flags are single-cycle pulses following the offending edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_ev;
            udf_q <= udf_ev;
        end
    end

    // clr_err has no function in this build.
    logic unused_clr_err;
    assign unused_clr_err = bus.clr_err;
`endif

    // Top-of-stack read; zeros whenever the stack is empty.
    always_comb begin
        bus.dout = '0;
        if (!empty_w) begin
            bus.dout = mem[top_idx];
        end
    end

    assign bus.count = cnt_q;
    assign bus.empty = empty_w;
    assign bus.full  = full_w;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;

endmodule

// File: tb/tb_pilha_param.sv
// tb_pilha_param -- self-checking bench for pilha_param (DEPTH=4, DATA_W=32).
// Expected values come from a queue-based stack model; the flag model
// follows the same build macro (PILHA_ERR_STICKY_EN) as the design.
module tb_pilha_param;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst;

    pilha_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    pilha_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [DATA_W-1:0] exp_q[$];
    logic              ovf_m;
    logic              udf_m;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] top;
        int sz;
        sz  = exp_q.size();
        top = (sz > 0) ? exp_q[sz-1] : '0;
        chk({tag, ".count"}, DATA_W'(bus.count), DATA_W'(sz));
        chk({tag, ".empty"}, DATA_W'(bus.empty), DATA_W'(sz == 0));
        chk({tag, ".full"},  DATA_W'(bus.full),  DATA_W'(sz == DEPTH));
        chk({tag, ".dout"},  bus.dout, top);
        chk({tag, ".ovf"},   DATA_W'(bus.ovf),   DATA_W'(ovf_m));
        chk({tag, ".udf"},   DATA_W'(bus.udf),   DATA_W'(udf_m));
    endtask

    task automatic model_reset();
        exp_q.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
    endtask

    // Driver: apply one request cycle, update the model, check after the edge.
    task automatic step(input string tag, input bit p, input bit q,
                        input logic [DATA_W-1:0] d, input bit c);
        bit ovf_ev;
        bit udf_ev;
        bus.push    = p;
        bus.pop     = q;
        bus.din     = d;
        bus.clr_err = c;
        @(posedge clk);
        ovf_ev = 1'b0;
        udf_ev = 1'b0;
        if (p && !q) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else                      ovf_ev = 1'b1;
        end else if (q && !p) begin
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            else                  udf_ev = 1'b1;
        end else if (p && q) begin
            if (exp_q.size() == 0) exp_q.push_back(d);
            else                   exp_q[exp_q.size()-1] = d;
        end
`ifdef PILHA_ERR_STICKY_EN
        ovf_m = ovf_ev | (ovf_m & ~c);
        udf_m = udf_ev | (udf_m & ~c);
`else
        ovf_m = ovf_ev;
        udf_m = udf_ev;
`endif
        #1;
        check_all(tag);
    endtask

    initial begin
        int thresh;
        bit p;
        bit q;
        bit c;

        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.din     = '0;
        bus.clr_err = 1'b0;
        model_reset();

        // Reset state, before any clock edge
        rst = 1'b0;
        #1;
        check_all("reset");
        #13;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset");

        // Fill to full
        step("push11", 1, 0, 32'h11, 0);
        step("push22", 1, 0, 32'h22, 0);
        step("push33", 1, 0, 32'h33, 0);
        step("push44", 1, 0, 32'h44, 0);
        chk("full_dout_44", bus.dout, 32'h44);

        // Overflow, then see the flag decay or stick, then clear
        step("ovf_push55", 1, 0, 32'h55, 0);
        chk("ovf_dout_kept", bus.dout, 32'h44);
        step("ovf_idle", 0, 0, 32'h0, 0);
        step("ovf_clr", 0, 0, 32'h0, 1);

        // Drain
        step("pop_to33", 0, 1, 32'h0, 0);
        step("pop_to22", 0, 1, 32'h0, 0);
        step("pop_to11", 0, 1, 32'h0, 0);
        step("pop_to0",  0, 1, 32'h0, 0);
        chk("drained_dout_zero", bus.dout, 32'h0);

        // Underflow, then push&pop on empty acts as push
        step("udf_pop", 0, 1, 32'h0, 0);
        step("udf_idle", 0, 0, 32'h0, 0);
        step("pp_empty77", 1, 1, 32'h77, 0);
        chk("pp_empty_dout_77", bus.dout, 32'h77);

        // Replace top at count=2
        step("pop_77", 0, 1, 32'h0, 0);
        step("clr0", 0, 0, 32'h0, 1);
        step("push11b", 1, 0, 32'h11, 0);
        step("push22b", 1, 0, 32'h22, 0);
        step("pp_99", 1, 1, 32'h99, 0);
        chk("replace_dout_99", bus.dout, 32'h99);
        step("pop_after_pp", 0, 1, 32'h0, 0);
        chk("after_replace_dout_11", bus.dout, 32'h11);
        step("pop_last", 0, 1, 32'h0, 0);

        // Set-wins-over-clear on underflow, then clear alone
        step("udf_set", 0, 1, 32'h0, 0);
        step("udf_clr_and_pop", 0, 1, 32'h0, 1);
        step("udf_clr_alone", 0, 0, 32'h0, 1);

        // Push/pop replace when full (no error)
        for (int i = 0; i < DEPTH; i++) step("fill_again", 1, 0, DATA_W'(32'hA0 + i), 0);
        step("pp_full", 1, 1, 32'hEE, 0);
        for (int i = 0; i < DEPTH; i++) step("drain_again", 0, 1, 32'h0, 0);

        // Asynchronous reset mid-operation
        step("pre_rst_a", 1, 0, 32'h01, 0);
        step("pre_rst_b", 1, 0, 32'h02, 0);
        step("pre_rst_c", 1, 0, 32'h03, 0);
        bus.push = 1'b0;
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #2;
        rst = 1'b1;
        step("post_rst_pushAB", 1, 0, 32'hAB, 0);
        chk("post_rst_dout_AB", bus.dout, 32'hAB);

        // Randomized phase, alternating push-heavy and pop-heavy windows
        for (int n = 0; n < 400; n++) begin
            thresh = ((n / 40) % 2 == 0) ? 70 : 30;
            p = ($urandom_range(0, 99) < thresh);
            q = ($urandom_range(0, 99) < (100 - thresh));
            c = ($urandom_range(0, 9) == 0);
            step("rand", p, q, $urandom, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
